// File: rtl/serial_alu8_pkg.sv
// serial_alu8_pkg: opcodes, FSM state encoding and gate helpers shared by the
// bit-serial ALU, its 1-bit slice and the NOT stage.
// Contents: OP_* opcodes, state_t (S_IDLE/S_EXEC), nand2(), is_arith().
package serial_alu8_pkg;

  localparam logic [2:0] OP_NOT  = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_OR   = 3'b010;
  localparam logic [2:0] OP_XOR  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_PASS = 3'b111;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EXEC = 1'b1
  } state_t;

  // Every gate in the datapath is expressed through this primitive.
  function automatic logic nand2(input logic x, input logic y);
    return ~(x & y);
  endfunction

  // Ops whose carry chain is live (ADD, SUB, INC).
  function automatic logic is_arith(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_INC);
  endfunction

endpackage

// File: rtl/serial_alu8_if.sv
// serial_alu8_if: request/result bundle between operand registers, the ALU and
// the result bus. master drives start/op/a/b; slave (the ALU) drives
// busy/done/out/carry/zero.
interface serial_alu8_if;

  logic       start;
  logic [2:0] op;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic [7:0] out;
  logic       carry;
  logic       zero;

  modport master (
    output start, op, a, b,
    input  busy, done, out, carry, zero
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, out, carry, zero
  );

endinterface

// File: rtl/bit_slice1.sv
// bit_slice1: one-bit ALU slice (logic ops + full adder) built from NANDs.
// Latency: combinational. Backpressure: none.
// Ports: a_i, b_i, cin_i, op_i[2:0] in; r_o result bit, cout_o carry out.
module bit_slice1
  import serial_alu8_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic [2:0] op_i,
  output logic       r_o,
  output logic       cout_o
);

  logic n_ab, n_a, n_b;
  logic and_ab, or_ab, xor_ab;
  logic n_xc, sum;

  assign n_ab   = nand2(a_i, b_i);
  assign n_a    = nand2(a_i, a_i);
  assign n_b    = nand2(b_i, b_i);
  assign and_ab = nand2(n_ab, n_ab);
  assign or_ab  = nand2(n_a, n_b);
  // Classic four-NAND XOR, reusing n_ab as the shared first gate.
  assign xor_ab = nand2(nand2(a_i, n_ab), nand2(b_i, n_ab));
  assign n_xc   = nand2(xor_ab, cin_i);
  assign sum    = nand2(nand2(xor_ab, n_xc), nand2(cin_i, n_xc));
  // cout = a&b | (a^b)&cin
  assign cout_o = nand2(n_ab, n_xc);

  always_comb begin
    r_o = a_i;
    case (op_i)
      OP_AND:                 r_o = and_ab;
      OP_OR:                  r_o = or_ab;
      OP_XOR:                 r_o = xor_ab;
      OP_ADD, OP_SUB, OP_INC: r_o = sum;
      // NOT: operand a was inverted at capture, so the slice passes it.
      default:                r_o = a_i;
    endcase
  end

endmodule

// File: rtl/not8.sv
// not8: 8-bit inverter stage, each bit a NAND with both inputs tied.
// Latency: combinational. Backpressure: none.
// Ports: a_i[7:0] in, y_o[7:0] = ~a_i out.
module not8
  import serial_alu8_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  always_comb begin
    y_o = 8'h00;
    for (int i = 0; i < 8; i++) begin
      y_o[i] = nand2(a_i[i], a_i[i]);
    end
  end

endmodule

// File: rtl/serial_alu8.sv
// serial_alu8: bit-serial 8-bit ALU, one bit per clock LSB-first.
// Latency: 8 clocks start edge -> result edge; one op in flight at a time.
// Backpressure: start is only sampled while idle; requests while busy are dropped.
// Ports: clk, reset (sync, active-high); bus (slave): start/op/a/b in,
//        busy/done/out/carry/zero out.
module serial_alu8
  import serial_alu8_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  serial_alu8_if.slave bus
);

  state_t     state_q;
  logic [2:0] cnt_q;
  logic [2:0] op_q;
  logic [7:0] a_q, b_q, res_q;
  logic       c_q;
  logic       busy_q, done_q, carry_q, zero_q;
  logic [7:0] out_q;

  logic [7:0] a_inv, b_inv;
  logic [7:0] a_cap, b_cap;
  logic       c_seed;
  logic       slice_r, slice_cout;
  logic [7:0] res_d;

  not8 u_not_a (.a_i(bus.a), .y_o(a_inv));
  not8 u_not_b (.a_i(bus.b), .y_o(b_inv));

  // Operand conditioning at capture: NOT inverts a, SUB inverts b,
  // INC adds zero with a carry-in of one.
  always_comb begin
    a_cap  = (bus.op == OP_NOT) ? a_inv : bus.a;
    b_cap  = bus.b;
    if (bus.op == OP_SUB) b_cap = b_inv;
    if (bus.op == OP_INC) b_cap = 8'h00;
    c_seed = (bus.op == OP_SUB) || (bus.op == OP_INC);
  end

  bit_slice1 u_slice (
    .a_i   (a_q[0]),
    .b_i   (b_q[0]),
    .cin_i (c_q),
    .op_i  (op_q),
    .r_o   (slice_r),
    .cout_o(slice_cout)
  );

  // New bit enters at the top; after 8 shifts bit 0 sits at the bottom.
  assign res_d = {slice_r, res_q[7:1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      op_q    <= OP_NOT;
      a_q     <= 8'h00;
      b_q     <= 8'h00;
      res_q   <= 8'h00;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= 8'h00;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            state_q <= S_EXEC;
            cnt_q   <= 3'd0;
            op_q    <= bus.op;
            a_q     <= a_cap;
            b_q     <= b_cap;
            c_q     <= c_seed;
            res_q   <= 8'h00;
            busy_q  <= 1'b1;
          end
        end
        S_EXEC: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= res_d;
          cnt_q <= cnt_q + 3'd1;
          if (is_arith(op_q)) c_q <= slice_cout;
          if (cnt_q == 3'd7) begin
            out_q   <= res_d;
            carry_q <= is_arith(op_q) ? slice_cout : 1'b0;
            zero_q  <= (res_d == 8'h00);
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.out   = out_q;
  assign bus.carry = carry_q;
  assign bus.zero  = zero_q;

endmodule

// File: tb/tb_serial_alu8.sv
// tb_serial_alu8: scoreboard bench for serial_alu8 with directed and random ops.
module tb_serial_alu8;

  typedef struct packed {
    logic [7:0] out;
    logic       carry;
    logic       zero;
  } exp_t;

  logic clk;
  logic reset;
  serial_alu8_if bus ();

  serial_alu8 dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  logic prev_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model from the arithmetic definition of each opcode.
  function automatic exp_t model(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    logic [8:0] wide;
    e.carry = 1'b0;
    case (op)
      3'd0: e.out = ~a;
      3'd1: e.out = a & b;
      3'd2: e.out = a | b;
      3'd3: e.out = a ^ b;
      3'd4: begin wide = {1'b0, a} + {1'b0, b}; e.out = wide[7:0]; e.carry = wide[8]; end
      3'd5: begin e.out = a - b; e.carry = (a >= b); end
      3'd6: begin wide = {1'b0, a} + 9'd1; e.out = wide[7:0]; e.carry = wide[8]; end
      default: e.out = a;
    endcase
    e.zero = (e.out == 8'h00);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no operation outstanding at %0t", $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_out", {24'h0, bus.out}, {24'h0, e.out});
        chk("result_carry", {31'h0, bus.carry}, {31'h0, e.carry});
        chk("result_zero", {31'h0, bus.zero}, {31'h0, e.zero});
      end
      chk("busy_done_exclusive", {31'h0, bus.busy}, 32'h0);
      chk("done_not_consecutive", {31'h0, prev_done}, 32'h0);
    end
    prev_done = bus.done;
  end

  // Issue one op and check busy/done timing edge by edge. With poke set, a
  // bogus start is pulsed mid-execution and must be ignored.
  task automatic run_op(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                        input bit poke);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sb.push_back(model(op, a, b));
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.a     = 8'($urandom);
    bus.b     = 8'($urandom);
    bus.op    = 3'($urandom);
    chk("busy_after_start", {31'h0, bus.busy}, 32'h1);
    for (int k = 1; k <= 8; k++) begin
      if (poke && k == 3) begin
        bus.start = 1'b1;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        bus.op    = 3'($urandom);
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k < 8) begin
        chk("busy_during_exec", {31'h0, bus.busy}, 32'h1);
        chk("no_early_done", {31'h0, bus.done}, 32'h0);
      end else begin
        chk("done_at_latency", {31'h0, bus.done}, 32'h1);
        chk("busy_clear_at_done", {31'h0, bus.busy}, 32'h0);
      end
    end
  endtask

  initial begin
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = 8'h00;
    bus.b     = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'h0, bus.busy}, 32'h0);
    chk("reset_done", {31'h0, bus.done}, 32'h0);
    chk("reset_out", {24'h0, bus.out}, 32'h0);
    chk("reset_carry", {31'h0, bus.carry}, 32'h0);
    chk("reset_zero", {31'h0, bus.zero}, 32'h0);
    reset = 1'b0;

    // Directed cases; consecutive calls put the next start in the done cycle.
    run_op(3'b100, 8'h0F, 8'h01, 1'b0);
    run_op(3'b100, 8'hFF, 8'h01, 1'b0);
    run_op(3'b110, 8'hFF, 8'h5A, 1'b0);
    run_op(3'b101, 8'h05, 8'h07, 1'b0);
    run_op(3'b101, 8'h07, 8'h07, 1'b0);
    run_op(3'b000, 8'hAA, 8'h33, 1'b0);
    run_op(3'b001, 8'h3C, 8'h0F, 1'b0);
    run_op(3'b010, 8'h12, 8'h80, 1'b0);
    run_op(3'b011, 8'hFF, 8'h12, 1'b0);
    run_op(3'b111, 8'h3C, 8'hC3, 1'b0);
    run_op(3'b100, 8'h81, 8'h81, 1'b1);
    run_op(3'b100, 8'hFF, 8'h02, 1'b0);

    // Reset at the fourth EXEC edge of an ADD: no done, outputs cleared,
    // and start held high during reset is ignored.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 3'b100;
    bus.a     = 8'h0F;
    bus.b     = 8'h01;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {31'h0, bus.busy}, 32'h0);
    chk("abort_done", {31'h0, bus.done}, 32'h0);
    chk("abort_out", {24'h0, bus.out}, 32'h0);
    chk("abort_carry", {31'h0, bus.carry}, 32'h0);
    chk("abort_zero", {31'h0, bus.zero}, 32'h0);
    @(posedge clk); #1;
    reset     = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("start_ignored_in_reset", {31'h0, bus.busy}, 32'h0);
    repeat (10) @(posedge clk);
    run_op(3'b100, 8'h0F, 8'h01, 1'b0);

    // Randomized ops with occasional idle gaps and mid-exec start pokes.
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) @(negedge clk);
      run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
             ($urandom_range(0, 3) == 0));
    end

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
